// File: rtl/m_ext_pkg.sv
// m_ext_pkg: shared RV32M funct3 codes, FSM encodings and special-case constants
package m_ext_pkg;
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
endpackage

// File: rtl/m_ext_if.sv
// m_ext_if: request/result bundle between the pipeline (master) and the M-extension unit (slave)
interface m_ext_if;
    logic        ip_start;
    logic [2:0]  ip_funct_3;
    logic [31:0] ip_operand_a;
    logic [31:0] ip_operand_b;
    logic        ip_flush;
    logic        op_busy;
    logic        op_stall;
    logic        op_done;
    logic [31:0] op_result;
    modport master (output ip_start, ip_funct_3, ip_operand_a, ip_operand_b, ip_flush,
                    input op_busy, op_stall, op_done, op_result);
    modport slave (input ip_start, ip_funct_3, ip_operand_a, ip_operand_b, ip_flush,
                   output op_busy, op_stall, op_done, op_result);
endinterface

// File: rtl/m_ext_iter_step.sv
// m_ext_iter_step: one combinational shift-add (multiply) or restoring trial-subtract (divide) iteration
module m_ext_iter_step (
    input  logic        i_div,
    input  logic [63:0] i_acc,
    input  logic [63:0] i_mc,
    input  logic [31:0] i_mr,
    output logic [63:0] o_acc,
    output logic [63:0] o_mc,
    output logic [31:0] o_mr
);
    logic [32:0] w_trial;
    // divide packs {remainder, dividend/quotient} in i_acc; divisor sits in i_mc[31:0]
    always_comb begin
        w_trial = {i_acc[63:32], i_acc[31]} - {1'b0, i_mc[31:0]};
        o_acc = i_div ? (w_trial[32] ? {i_acc[62:0], 1'b0} : {w_trial[31:0], i_acc[30:0], 1'b1})
                      : i_acc + (i_mr[0] ? i_mc : 64'd0);
        o_mc = i_div ? i_mc : i_mc << 1;
        o_mr = i_div ? i_mr : i_mr >> 1;
    end
endmodule

// File: rtl/m_ext_seq.sv
// m_ext_seq: RV32M multi-cycle sequencer; define M_EXT_EARLY_OUT_EN to end multiplies once the multiplier is exhausted
module m_ext_seq
    import m_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic   ip_clk,
    input logic   ip_rst_n,
    m_ext_if.slave bus
);
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic [63:0]      r_acc, r_mc;
    logic [31:0]      r_mr, r_result;
    logic             r_neg;
    logic        w_div, w_sa, w_sb, w_an, w_bn, w_div0, w_ovf, w_last;
    logic [31:0] w_ma, w_mb, w_spec, w_q, w_r, w_fin;
    logic [63:0] w_acc_n, w_mc_n, w_prod;
    logic [31:0] w_mr_n;

    always_comb begin
        w_div  = bus.ip_funct_3[2];
        w_sa   = bus.ip_funct_3 inside {FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_DIV, FUNCT3_REM};
        w_sb   = bus.ip_funct_3 inside {FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM};
        w_an   = w_sa & bus.ip_operand_a[31];
        w_bn   = w_sb & bus.ip_operand_b[31];
        w_ma   = w_an ? -bus.ip_operand_a : bus.ip_operand_a;
        w_mb   = w_bn ? -bus.ip_operand_b : bus.ip_operand_b;
        w_div0 = w_div & (bus.ip_operand_b == '0);
        w_ovf  = (bus.ip_funct_3 == FUNCT3_DIV || bus.ip_funct_3 == FUNCT3_REM) &
                 (bus.ip_operand_a == INT_MIN) & (bus.ip_operand_b == '1);
        w_spec = w_div0 ? (bus.ip_funct_3[1] ? bus.ip_operand_a : DIV0_QUOT)
                        : (bus.ip_funct_3[1] ? 32'd0 : INT_MIN);
        w_prod = r_neg ? -w_acc_n : w_acc_n;
        w_q    = w_acc_n[31:0];
        w_r    = w_acc_n[63:32];
        w_fin  = !r_f3[2] ? (r_f3 == FUNCT3_MUL ? w_prod[31:0] : w_prod[63:32])
               : r_f3[1] ? (r_neg ? -w_r : w_r) : (r_neg ? -w_q : w_q);
    end

`ifdef M_EXT_EARLY_OUT_EN
    // a multiply cycle that sees no multiplier bits left performs a no-op step and finishes
    assign w_last = r_f3[2] ? (r_cnt == CNT_W'(XLEN - 1)) : (r_mr == '0);
`else
    assign w_last = r_cnt == CNT_W'(XLEN - 1);
`endif

    m_ext_iter_step u_step (
        .i_div (r_f3[2]),
        .i_acc (r_acc),
        .i_mc  (r_mc),
        .i_mr  (r_mr),
        .o_acc (w_acc_n),
        .o_mc  (w_mc_n),
        .o_mr  (w_mr_n)
    );

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_acc    <= '0;
            r_mc     <= '0;
            r_mr     <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (bus.ip_flush) begin
            r_state <= ST_IDLE;
        end else if (r_state == ST_IDLE && bus.ip_start) begin
            r_f3  <= bus.ip_funct_3;
            r_cnt <= '0;
            r_neg <= w_div & bus.ip_funct_3[1] ? w_an : w_an ^ w_bn;
            r_acc <= w_div ? {32'd0, w_ma} : 64'd0;
            r_mc  <= {32'd0, w_div ? w_mb : w_ma};
            r_mr  <= w_div ? 32'd0 : w_mb;
            if (w_div0 | w_ovf) begin
                r_state  <= ST_DONE;
                r_result <= w_spec;
            end else begin
                r_state <= ST_CALC;
            end
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_n;
            r_mc  <= w_mc_n;
            r_mr  <= w_mr_n;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_state  <= ST_DONE;
                r_result <= w_fin;
            end
        end else begin
            r_state <= ST_IDLE;
        end
    end

    assign bus.op_busy   = r_state == ST_CALC || r_state == ST_DONE;
    assign bus.op_stall  = (r_state == ST_IDLE && bus.ip_start) || r_state == ST_CALC;
    assign bus.op_done   = r_state == ST_DONE;
    assign bus.op_result = r_result;
endmodule

// File: tb/tb_m_ext_seq.sv
// tb_m_ext_seq: directed table-driven check of m_ext_seq results, latency, stall, flush and reset
module tb_m_ext_seq;
    import m_ext_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    m_ext_if bus ();
    m_ext_seq dut (.ip_clk(clk), .ip_rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          nb;
    } vec_t;

    vec_t        tbl [21];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_res;
    logic        seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // nb is the hand-counted bit length of |b|, used only when multiplies end early
    function automatic int exp_lat(input vec_t v);
`ifdef M_EXT_EARLY_OUT_EN
        return (v.f3[2] || v.lat == 1) ? v.lat : 2 + v.nb;
`else
        return v.lat;
`endif
    endfunction

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        int st;
        n = 1;
        st = 0;
        tick;
        bus.ip_funct_3   = f3;
        bus.ip_operand_a = a;
        bus.ip_operand_b = b;
        bus.ip_start     = 1'b1;
        #1;
        if (bus.op_stall) st++;
        tick;
        bus.ip_start = 1'b0;
        #1;
        while (!bus.op_done && n < 80) begin
            if (bus.op_stall) st++;
            tick;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " result"}, bus.op_result, exp);
        check({name, " stall_at_done"}, {31'd0, bus.op_stall}, 32'd0);
        check({name, " stall_cycles"}, 32'(st), 32'(lat));
        check({name, " busy_at_done"}, {31'd0, bus.op_busy}, 32'd1);
    endtask

    initial begin
        bus.ip_start = 1'b0;
        bus.ip_flush = 1'b0;
        bus.ip_funct_3 = '0;
        bus.ip_operand_a = '0;
        bus.ip_operand_b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst busy", {31'd0, bus.op_busy}, 32'd0);
        check("rst stall", {31'd0, bus.op_stall}, 32'd0);
        check("rst done", {31'd0, bus.op_done}, 32'd0);
        check("rst result", bus.op_result, 32'd0);
        rst_n = 1'b1;
        tick;
        check("post_rst busy", {31'd0, bus.op_busy}, 32'd0);

        tbl[0]  = '{FUNCT3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32};
        tbl[1]  = '{FUNCT3_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 2};
        tbl[2]  = '{FUNCT3_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 33, 2};
        tbl[3]  = '{FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32};
        tbl[4]  = '{FUNCT3_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 33, 17};
        tbl[5]  = '{FUNCT3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 32};
        tbl[6]  = '{FUNCT3_MULHU,  32'h00000005, 32'h00000003, 32'h00000000, 33, 2};
        tbl[7]  = '{FUNCT3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 32};
        tbl[8]  = '{FUNCT3_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 0};
        tbl[9]  = '{FUNCT3_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 0};
        tbl[10] = '{FUNCT3_DIVU,   32'd100,      32'd7,        32'd14,       33, 0};
        tbl[11] = '{FUNCT3_REMU,   32'd100,      32'd7,        32'd2,        33, 0};
        tbl[12] = '{FUNCT3_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0};
        tbl[13] = '{FUNCT3_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33, 0};
        tbl[14] = '{FUNCT3_DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33, 0};
        tbl[15] = '{FUNCT3_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1, 0};
        tbl[16] = '{FUNCT3_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 1, 0};
        tbl[17] = '{FUNCT3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0};
        tbl[18] = '{FUNCT3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0};
        tbl[19] = '{FUNCT3_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1, 0};
        tbl[20] = '{FUNCT3_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1, 0};
        last_res = '0;
        for (int i = 0; i < 21; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res, exp_lat(tbl[i]));
            last_res = tbl[i].res;
        end

        // start asserted during DONE must be ignored
        bus.ip_funct_3 = FUNCT3_DIVU;
        bus.ip_operand_a = 32'd7;
        bus.ip_operand_b = 32'd0;
        bus.ip_start = 1'b1;
        tick;
        bus.ip_start = 1'b0;
        #1;
        check("done_start busy", {31'd0, bus.op_busy}, 32'd0);
        check("done_start done", {31'd0, bus.op_done}, 32'd0);

        bus.ip_start = 1'b1;
        bus.ip_flush = 1'b1;
        tick;
        bus.ip_start = 1'b0;
        bus.ip_flush = 1'b0;
        #1;
        check("flush_start busy", {31'd0, bus.op_busy}, 32'd0);
        check("flush_start done", {31'd0, bus.op_done}, 32'd0);
        check("flush_start result", bus.op_result, last_res);

        bus.ip_funct_3 = FUNCT3_MUL;
        bus.ip_operand_a = 32'd3;
        bus.ip_operand_b = 32'hFFFFFFFF;
        bus.ip_start = 1'b1;
        tick;
        bus.ip_start = 1'b0;
        repeat (9) tick;
        check("pre_flush busy", {31'd0, bus.op_busy}, 32'd1);
        bus.ip_flush = 1'b1;
        tick;
        bus.ip_flush = 1'b0;
        #1;
        check("flush busy", {31'd0, bus.op_busy}, 32'd0);
        check("flush stall", {31'd0, bus.op_stall}, 32'd0);
        check("flush done", {31'd0, bus.op_done}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (bus.op_done) seen = 1'b1;
            tick;
        end
        check("flush no_done", {31'd0, seen}, 32'd0);
        check("flush result_held", bus.op_result, last_res);
        run_op("divu_after_flush", FUNCT3_DIVU, 32'd9, 32'd3, 32'd3, 33);

        tick;
        bus.ip_funct_3 = FUNCT3_DIV;
        bus.ip_operand_a = 32'd100;
        bus.ip_operand_b = 32'd7;
        bus.ip_start = 1'b1;
        tick;
        bus.ip_start = 1'b0;
        repeat (5) tick;
        rst_n = 1'b0;
        #1;
        check("midrst busy", {31'd0, bus.op_busy}, 32'd0);
        check("midrst stall", {31'd0, bus.op_stall}, 32'd0);
        check("midrst done", {31'd0, bus.op_done}, 32'd0);
        check("midrst result", bus.op_result, 32'd0);
        tick;
        rst_n = 1'b1;
        run_op("divu_after_rst", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m_ext_seq.md
Name: m_ext_seq

Overview:
- Multi-cycle sequencer and datapath for the RV32M instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU and is selected by the decoder's M-extension write-back control.
- Accepts one operation at a time and stalls the pipeline while it iterates.
- Presents a 32-bit result with a one-cycle done pulse for register write-back.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- CNT_W, 6, width of the iteration counter. Must satisfy 2^CNT_W > XLEN.

Ports:
- ip_clk  input  1  system clock, rising edge
- ip_rst_n  input  1  asynchronous active-low reset
- ip_start  input  1  request a new M-extension operation; sampled only in IDLE
- ip_funct_3  input  3  operation select, RV32M funct3 encoding
- ip_operand_a  input  32  rs1 value
- ip_operand_b  input  32  rs2 value
- ip_flush  input  1  abort the current operation (branch or jump redirect)
- op_busy  output  1  high while in CALC or DONE
- op_stall  output  1  pipeline hold request
- op_done  output  1  one-cycle pulse; op_result is valid in this cycle
- op_result  output  32  final result, registered

Behaviour:
- Clock and reset: single clock ip_clk. Reset ip_rst_n is asynchronous and active-low.
- Reset values: state=IDLE, counter=0, internal registers=0, op_busy=0, op_stall=0, op_done=0, op_result=0.

FSM states:
- IDLE: waits for ip_start.
- CALC: iterates.
- DONE: drives the result for one cycle, then returns to IDLE.

Start and latency:
- IDLE with ip_start=1 and no special case: latch funct3, latch operand magnitudes and result-sign flags, clear counter, go to CALC.
- CALC runs exactly 32 cycles (counter 0..31), then goes to DONE.
- op_done is high in the DONE cycle only. Start in cycle N gives op_done in cycle N+33.

Stall:
- op_stall = (IDLE & ip_start) | CALC.
- op_stall is combinational and deasserts in DONE, so the pipeline advances in the same cycle it consumes op_result.

Handshake:
- ip_start is ignored outside IDLE.
- Back-to-back operations: a new ip_start is accepted in the IDLE cycle following DONE.

Multiply:
- Radix-2 shift-add on the 64-bit product register.
- Signed operands are converted to magnitudes before iterating. The product is negated at DONE entry if the result sign is set.
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
- MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].

Divide:
- Restoring division, one quotient bit per cycle, on magnitudes.
- Quotient sign = sign(a) XOR sign(b), applied only for DIV.
- Remainder sign = sign(a), applied only for REM.

Special cases (go IDLE -> DONE directly; op_done appears at N+1 with op_stall high only in cycle N):
- Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return a.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.

Other rules:
- Flush: ip_flush=1 in any state forces IDLE on the next edge. No op_done is issued and op_result holds its last value. Flush in the same cycle as start wins, and the start is dropped.
- Reset asserted mid-operation returns all state to reset values immediately.
- Arithmetic: all negation is two's complement modulo 2^64 for products and 2^32 for quotient and remainder. No exceptions are raised.

Optional Feature:
- Macro: M_EXT_EARLY_OUT_EN
- Defined: during multiply CALC, if the remaining unshifted multiplier magnitude is zero, jump to DONE on the next edge. Latency is then 2 + (index of the highest set bit of |b|) + 1 cycles. Results are identical.
- Undefined: fixed 32-cycle CALC for all operations; divide is unaffected in both cases.

Decomposition:
- Shared package m_ext_pkg holds:
  - funct3 constants FUNCT3_MUL..FUNCT3_REMU (3'b000..3'b111)
  - state encodings ST_IDLE, ST_CALC, ST_DONE
  - constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000
- One natural sub-module, m_ext_iter_step: combinational single-iteration step.
  - Multiply: add-and-shift.
  - Divide: trial-subtract-and-shift.
  - Inputs: mode and current accumulator/operand registers. Outputs: next values.
  - m_ext_seq keeps the FSM, counter, sign handling and registers.

Test Plan:
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF, start at N -> op_done at N+33, op_result=0xFFFFFFFE; op_stall high N..N+32.
- MULH a=0xFFFFFFFF (-1), b=0x00000002 -> op_result=0xFFFFFFFF; MUL with the same operands -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14.
- DIVU a=0x12345678, b=0 -> op_done at N+1, result 0xFFFFFFFF; REMU with the same operands -> 0x12345678; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at N+1.
- Start MUL, assert ip_flush at N+10 -> IDLE at N+11, no op_done, op_stall low. Then start DIVU 9/3 -> result 3 at start+33. Also check ip_rst_n pulsed low mid-CALC clears all outputs asynchronously.
- With M_EXT_EARLY_OUT_EN defined: MULHU a=5, b=3 -> op_done at N+4, result 0; without the macro -> N+33, result 0.
